// File: rtl/imem_fetch_responder_pkg.sv
// Shared definitions for the instruction-memory fetch responder:
// bubble encoding, FSM state encoding and byte-to-word address helper.
package imem_fetch_responder_pkg;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    function automatic logic [31:0] word_index(input logic [31:0] addr, input logic [31:0] base);
        word_index = (addr - base) >> 2;
    endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: synchronous write port, asynchronous read port.
// Contents are deliberately not cleared by reset.
module imem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/imem_fetch_responder.sv
// Fetch responder: accepts a PC, returns the instruction word LATENCY cycles
// later, with address checking, flush of outstanding fetches and a load port.
module imem_fetch_responder
    import imem_fetch_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR   = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_ready,
    input  logic        fetch_flush,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic        addr_err,
    input  logic        load_we,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

    state_t         r_state;
    state_t         w_state_next;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_cnt_next;
    logic [31:0]    r_pend_instr;
    logic           r_pend_err;
    logic [31:0]    r_hold_instr;

    logic [31:0]    w_fetch_idx;
    logic [31:0]    w_load_idx;
    logic           w_fetch_err;
    logic           w_load_ok;
    logic           w_accept;
    logic [31:0]    w_rd_data;

    assign w_fetch_idx = word_index(fetch_addr, BASE_ADDR);
    assign w_load_idx  = word_index(load_addr, BASE_ADDR);

    assign w_fetch_err = (fetch_addr[1:0] != 2'b00) || (fetch_addr < BASE_ADDR)
                      || (w_fetch_idx >= 32'(DEPTH_WORDS));
    assign w_load_ok   = load_we && (load_addr[1:0] == 2'b00) && (load_addr >= BASE_ADDR)
                      && (w_load_idx < 32'(DEPTH_WORDS));

    assign fetch_ready = (r_state != S_WAIT);
    assign w_accept    = fetch_req && fetch_ready;

    // Read is combinational, so a same-edge load cannot affect the captured word.
    imem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk     (clk),
        .i_we    (w_load_ok),
        .i_waddr (w_load_idx[AW-1:0]),
        .i_wdata (load_data),
        .i_raddr (w_fetch_idx[AW-1:0]),
        .o_rdata (w_rd_data)
    );

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE, S_RESP: begin
                if (w_accept) begin
                    if (LATENCY == 1) begin
                        w_state_next = S_RESP;
                    end else begin
                        w_state_next = S_WAIT;
                        w_cnt_next   = CW'(LATENCY - 2);
                    end
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_WAIT: begin
                if (fetch_flush) begin
                    w_state_next = S_IDLE;
                end else if (r_cnt == '0) begin
                    w_state_next = S_RESP;
                end else begin
                    w_cnt_next = r_cnt - CW'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_pend_instr <= NOP_INSTR;
            r_pend_err   <= 1'b0;
            r_hold_instr <= NOP_INSTR;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_pend_instr <= w_fetch_err ? NOP_INSTR : w_rd_data;
                r_pend_err   <= w_fetch_err;
            end
            // Remember the presented word so instr_out is stable between pulses.
            if (r_state == S_RESP) begin
                r_hold_instr <= r_pend_instr;
            end
        end
    end

    assign instr_valid = (r_state == S_RESP);
    assign instr_out   = instr_valid ? r_pend_instr : r_hold_instr;
    assign addr_err    = instr_valid && r_pend_err;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Scoreboard bench: three responders (LATENCY 2, 1, 3) share memory load and
// reset; each has its own request/flush lines and its own expected responses.
module tb_imem_fetch_responder;

    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0000;

    typedef struct {
        int          dut;
        int          acc;
        int          cyc;
        logic [31:0] data;
        logic        err;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  fetch_req;
    logic [31:0] fetch_addr;
    logic [2:0]  fetch_ready;
    logic [2:0]  fetch_flush;
    logic [2:0]  instr_valid;
    logic [31:0] instr_out [3];
    logic [2:0]  addr_err;
    logic        load_we;
    logic [31:0] load_addr;
    logic [31:0] load_data;

    logic [31:0] model [DEPTH];
    sb_t         sbq [$];
    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        imem_fetch_responder #(
            .DEPTH_WORDS (DEPTH),
            .LATENCY     ((gi == 0) ? 2 : ((gi == 1) ? 1 : 3)),
            .BASE_ADDR   (BASE),
            .NOP_INSTR   (NOP)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .fetch_req   (fetch_req[gi]),
            .fetch_addr  (fetch_addr),
            .fetch_ready (fetch_ready[gi]),
            .fetch_flush (fetch_flush[gi]),
            .instr_valid (instr_valid[gi]),
            .instr_out   (instr_out[gi]),
            .addr_err    (addr_err[gi]),
            .load_we     (load_we),
            .load_addr   (load_addr),
            .load_data   (load_data)
        );
    end

    function automatic int lat_of(input int k);
        case (k)
            0:       return 2;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    function automatic logic [32:0] model_fetch(input logic [31:0] a);
        logic [31:0] off;
        off = (a - BASE) >> 2;
        if (a[1:0] != 2'b00 || a < BASE || off >= 32'(DEPTH)) return {1'b1, NOP};
        return {1'b0, model[int'(off)]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Drop responses of dut k still outstanding when the flush/reset edge e arrives.
    task automatic drop_pending(input int k, input int e);
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if ((k < 0 || sbq[i].dut == k) && sbq[i].acc < e && sbq[i].cyc >= e) sbq.delete(i);
        end
    endtask

    task automatic issue(input int k, input logic [31:0] a);
        logic [32:0] e;
        sb_t         s;
        e = model_fetch(a);
        fetch_req    = '0;
        fetch_req[k] = 1'b1;
        fetch_addr   = a;
        n_total++;
        if (fetch_ready[k] !== 1'b1)
            $display("FAIL ready_at_accept dut%0d addr=%h got=%b want=1", k, a, fetch_ready[k]);
        else n_pass++;
        s.dut  = k;
        s.acc  = cyc + 1;
        s.cyc  = cyc + lat_of(k);
        s.data = e[31:0];
        s.err  = e[32];
        sbq.push_back(s);
        $display("req  dut%0d edge=%0d addr=%h expect instr=%h err=%b at cycle %0d",
                 k, s.acc, a, s.data, s.err, s.cyc);
        step();
        fetch_req[k] = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] off;
        load_we   = 1'b1;
        load_addr = a;
        load_data = d;
        step();
        load_we = 1'b0;
        off = (a - BASE) >> 2;
        if (a[1:0] == 2'b00 && a >= BASE && off < 32'(DEPTH)) model[int'(off)] = d;
        $display("load addr=%h data=%h", a, d);
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                int idx;
                idx = -1;
                for (int i = 0; i < sbq.size(); i++) begin
                    if (sbq[i].dut == k && sbq[i].cyc <= cyc) begin
                        idx = i;
                        break;
                    end
                end
                if (idx >= 0) begin
                    n_total++;
                    if (instr_valid[k] !== 1'b1 || sbq[idx].cyc != cyc) begin
                        $display("FAIL resp_timing dut%0d cycle=%0d valid=%b want pulse at cycle %0d",
                                 k, cyc, instr_valid[k], sbq[idx].cyc);
                    end else begin
                        n_pass++;
                        $display("resp dut%0d cycle=%0d instr=%h err=%b", k, cyc, instr_out[k], addr_err[k]);
                        n_total++;
                        if (instr_out[k] !== sbq[idx].data)
                            $display("FAIL resp_data dut%0d got=%h want=%h", k, instr_out[k], sbq[idx].data);
                        else n_pass++;
                        n_total++;
                        if (addr_err[k] !== sbq[idx].err)
                            $display("FAIL resp_err dut%0d got=%b want=%b", k, addr_err[k], sbq[idx].err);
                        else n_pass++;
                    end
                    sbq.delete(idx);
                end else if (instr_valid[k] !== 1'b0) begin
                    n_total++;
                    $display("FAIL spurious_valid dut%0d cycle=%0d got=%b want=0", k, cyc, instr_valid[k]);
                end
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        for (int k = 0; k < 3; k++) begin
            n_total++;
            if (instr_valid[k] !== 1'b0 || instr_out[k] !== NOP || addr_err[k] !== 1'b0 || fetch_ready[k] !== 1'b1)
                $display("FAIL %s dut%0d got valid=%b instr=%h err=%b ready=%b want 0/%h/0/1",
                         tag, k, instr_valid[k], instr_out[k], addr_err[k], fetch_ready[k], NOP);
            else n_pass++;
        end
    endtask

    task automatic test_preload();
        for (int i = 0; i < DEPTH; i++) model[i] = NOP;
        load(32'h0, 32'h2008_0005);
        load(32'h4, 32'h2009_0003);
        load(32'h8, 32'h0109_5020);
        load(32'hC, 32'hAC0A_0000);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
        check_idle_outputs("reset_state");
    endtask

    task automatic test_latency2();
        issue(0, 32'h0);
        wait_cycles(4);
    endtask

    task automatic test_back_to_back();
        issue(1, 32'h0);
        issue(1, 32'h4);
        issue(1, 32'h8);
        wait_cycles(3);
    endtask

    task automatic test_addr_err();
        issue(0, 32'h6);
        wait_cycles(3);
        issue(0, 32'h400);
        wait_cycles(3);
        issue(2, 32'h401);
        wait_cycles(4);
    endtask

    task automatic test_flush();
        issue(2, 32'h4);
        fetch_flush[2] = 1'b1;
        drop_pending(2, cyc + 1);
        step();
        fetch_flush[2] = 1'b0;
        n_total++;
        if (fetch_ready[2] !== 1'b1) $display("FAIL ready_after_flush got=%b want=1", fetch_ready[2]);
        else n_pass++;
        issue(2, 32'h8);
        wait_cycles(5);
        // Flush while a pulse is presented: pulse stands, new request accepted.
        issue(1, 32'h0);
        fetch_flush[1] = 1'b1;
        drop_pending(1, cyc + 1);
        issue(1, 32'hC);
        fetch_flush[1] = 1'b0;
        wait_cycles(3);
        // Flush in idle is harmless.
        fetch_flush[0] = 1'b1;
        step();
        fetch_flush[0] = 1'b0;
        issue(0, 32'h4);
        wait_cycles(4);
    endtask

    task automatic test_load_collision();
        logic [31:0] off;
        load_we   = 1'b1;
        load_addr = 32'h4;
        load_data = 32'hDEAD_BEEF;
        issue(0, 32'h4);
        load_we = 1'b0;
        off = 32'h1;
        model[int'(off)] = 32'hDEAD_BEEF;
        $display("load addr=%h data=%h (same edge as fetch)", 32'h4, 32'hDEAD_BEEF);
        wait_cycles(3);
        issue(0, 32'h4);
        wait_cycles(3);
        load(32'h6, 32'h1111_1111);
        load(32'h400, 32'h2222_2222);
        issue(0, 32'h0);
        wait_cycles(3);
        issue(0, 32'h4);
        wait_cycles(3);
    endtask

    task automatic test_rst_mid();
        issue(2, 32'h0);
        rst = 1'b1;
        drop_pending(-1, cyc + 1);
        step();
        check_idle_outputs("reset_mid_wait");
        step();
        rst = 1'b0;
        wait_cycles(4);
        issue(2, 32'h4);
        wait_cycles(4);
        issue(2, 32'h0);
        wait_cycles(4);
    endtask

    initial begin
        rst         = 1'b1;
        fetch_req   = '0;
        fetch_addr  = '0;
        fetch_flush = '0;
        load_we     = 1'b0;
        load_addr   = '0;
        load_data   = '0;
        step();
        test_preload();
        test_reset();
        fork
            monitor();
        join_none
        test_latency2();
        test_back_to_back();
        test_addr_err();
        test_flush();
        test_load_collision();
        test_rst_mid();
        wait_cycles(6);
        n_total++;
        if (sbq.size() != 0) $display("FAIL drain outstanding=%0d want=0", sbq.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/imem_fetch_responder.md
Name: imem_fetch_responder

Overview:
- Instruction-memory responder on the far end of the core's fetch interface.
- The core's IF stage issues a word-aligned PC as a fetch request. This block answers with the 32-bit instruction after a fixed, parameterised latency.
- Supports flushing an outstanding fetch on a taken branch or jump.
- A separate load port lets the testbench preload the program before reset is released.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit instruction words; power of two, at least 4.
- LATENCY, 2, cycles from request accept to instr_valid; must be at least 1.
- BASE_ADDR, 32'h00000000, byte address of word 0.
- NOP_INSTR, 32'h00000000, instruction returned on error or flush-inserted bubble (sll $0,$0,0).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- fetch_req  input  1  core requests a fetch this cycle.
- fetch_addr  input  32  byte address (PC) of the requested instruction.
- fetch_ready  output  1  responder can accept a request this cycle.
- fetch_flush  input  1  cancel any outstanding fetch (branch/jump resolved in ID).
- instr_valid  output  1  one-cycle pulse; instr_out and addr_err are valid.
- instr_out  output  32  returned instruction word.
- addr_err  output  1  response is for a misaligned or out-of-range address.
- load_we  input  1  program-load write strobe.
- load_addr  input  32  byte address for the load write.
- load_data  input  32  word to write.

Behaviour:
- Reset:
  - state=IDLE, instr_valid=0, instr_out=NOP_INSTR, addr_err=0, latency counter=0.
  - Memory contents are NOT cleared by rst; simulation initialises every word to NOP_INSTR.
- States:
  - IDLE: fetch_ready=1.
  - WAIT: counting; fetch_ready=0.
  - RESP: instr_valid=1; fetch_ready=1.
- Accept: fetch_req and fetch_ready high at edge T.
  - The word is read at T and captured in a response register (read-before-write).
  - instr_valid=1 in the cycle after edge T+LATENCY-1, i.e. LATENCY cycles after accept.
  - LATENCY=1: IDLE/RESP -> RESP directly.
  - LATENCY>1: -> WAIT with the counter loaded to LATENCY-2. Counter decrements each cycle; at 0 go to RESP.
- RESP:
  - With a new accepted request, behave as for any accept: to WAIT, or stay in RESP if LATENCY=1. This gives one fetch per cycle at LATENCY=1.
  - Without a new request, go to IDLE and drop instr_valid.
- Address check:
  - Error when fetch_addr[1:0]!=0, fetch_addr<BASE_ADDR, or word index >= DEPTH_WORDS.
  - On error: instr_out=NOP_INSTR and addr_err=1, returned with the normal latency.
  - Word index = (fetch_addr-BASE_ADDR)>>2.
- Flush:
  - fetch_flush in WAIT: go to IDLE; the pending response is discarded and never asserts instr_valid.
  - fetch_flush in RESP: the current pulse stands, since it was already presented. Any request accepted in the same cycle is still accepted; flush applies only to fetches outstanding before that edge.
  - fetch_flush in IDLE has no effect.
- Load port:
  - load_we writes load_data to the word at load_addr at the edge.
  - Misaligned or out-of-range loads are silently ignored.
  - A load takes effect regardless of fetch state.
  - A load to the word being accepted in the same cycle leaves the fetch returning the OLD word. Fetches captured earlier are unaffected.
- rst mid-operation: the pending fetch is dropped; instr_valid=0 from the next cycle; state=IDLE.
- instr_out holds its last value when instr_valid=0.

Decomposition:
- Shared package: NOP_INSTR constant, state encoding (IDLE/WAIT/RESP), and the word-index helper function.
- One natural sub-module, imem_array: a DEPTH_WORDS x 32 array with a synchronous write port and an asynchronous read port.
- The FSM, latency counter and response register stay in the top module.

Test Plan:
- Preload word0=32'h20080005, word1=32'h20090003; rst 2 cycles; fetch_req at 0x0 with LATENCY=2 -> instr_valid pulses exactly 2 cycles after accept with instr_out=32'h20080005, addr_err=0.
- LATENCY=1, fetch_req held high with addresses 0x0, 0x4, 0x8 on consecutive cycles -> three back-to-back instr_valid pulses returning word0, word1, word2 in order; fetch_ready stays 1.
- Fetch 0x6 (misaligned) and 0x400 with DEPTH_WORDS=256 -> each returns instr_out=32'h00000000 and addr_err=1 with the normal latency.
- LATENCY=3: accept 0x4, assert fetch_flush one cycle later -> no instr_valid for that fetch; fetch_ready=1 the next cycle; a new fetch at 0x8 returns word2.
- load_we to 0x4 with 32'hDEADBEEF in the same cycle a fetch of 0x4 is accepted -> response is the old word1; a subsequent fetch of 0x4 returns 32'hDEADBEEF.
- Assert rst while in WAIT -> instr_valid never pulses for that fetch; outputs return to reset values; memory contents are retained.
